// File: rtl/clock_pkg.sv
// Shared definitions for the time-sync receiver and the clock top level.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_CHECK,
    ST_COMMIT
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         PAYLOAD_BYTES     = 8;

endpackage

// File: rtl/time_sync_rx_if.sv
// Byte stream from the UART receiver: one-cycle strobe, no backpressure.
interface time_sync_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (output rx_data, output rx_valid);
  modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/time_sync_rx_sync_timeout.sv
// Generic inactivity counter. The clearing cycle counts as cycle 1, so
// expired is high in the LIMIT-th cycle after clr (clr cycle included) and a
// registered reaction to it lands exactly LIMIT cycles after the clr strobe.
// LIMIT must be at least 2. Also intended for button long-press detection.
module sync_timeout #(
  parameter int unsigned LIMIT = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = en && !clr && (cnt_q >= CW'(LIMIT - 1));

  // Clear wins over counting; hold once the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = CW'(1);
    else if (en && !expired)
      cnt_d = cnt_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/time_sync_rx.sv
// Frame receiver feeding the clock top level: sync byte, 8 big-endian payload
// bytes, XOR checksum. Only a fully validated frame reaches intertime.
module time_sync_rx
  import clock_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
  parameter int unsigned PULSE_CYCLES   = 1,            // must be >= 1
  parameter logic [63:0] MAX_UNIX       = 64'h0000_0000_FFFF_FFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  time_sync_rx_if.slave        rx,
  output logic [63:0]          intertime,
  output logic                 issetintertime,
  output logic                 busy,
  output logic                 frame_ok,
  output logic                 frame_err
);

  localparam int IW = $clog2(PAYLOAD_BYTES);
  localparam int PW = $clog2(PULSE_CYCLES + 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [63:0]     shadow_q, shadow_d;
  logic [7:0]      xor_q, xor_d;
  logic [63:0]     intertime_q, intertime_d;
  logic [PW-1:0]   pulse_q, pulse_d;
  logic            iss_q, iss_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;
  logic            byte_acc;
  logic            tmo_expired;

  assign busy           = (state_q != ST_IDLE);
  assign intertime      = intertime_q;
  assign issetintertime = iss_q;
  assign frame_ok       = ok_q;
  assign frame_err      = err_q;

  sync_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (byte_acc),
    .en      (busy),
    .expired (tmo_expired)
  );

  // Frame FSM, shadow/checksum accumulation and load-pulse stretcher.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    xor_d       = xor_q;
    intertime_d = intertime_q;
    ok_d        = 1'b0;
    err_d       = 1'b0;
    byte_acc    = 1'b0;
    pulse_d     = (pulse_q != '0) ? pulse_q - PW'(1) : pulse_q;

    case (state_q)
      ST_IDLE: begin
        if (rx.rx_valid && rx.rx_data == SYNC_BYTE) begin
          state_d  = ST_PAYLOAD;
          idx_d    = '0;
          shadow_d = '0;
          xor_d    = '0;
          byte_acc = 1'b1;
        end
      end
      ST_PAYLOAD: begin
        // A sync byte here is plain data; there is deliberately no resync.
        if (rx.rx_valid) begin
          byte_acc = 1'b1;
          shadow_d = {shadow_q[55:0], rx.rx_data};
          xor_d    = xor_q ^ rx.rx_data;
          if (idx_q == IW'(PAYLOAD_BYTES - 1))
            state_d = ST_CHECK;
          else
            idx_d = idx_q + IW'(1);
        end else if (tmo_expired) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_CHECK: begin
        if (rx.rx_valid) begin
          byte_acc = 1'b1;
          if (rx.rx_data == xor_q && shadow_q <= MAX_UNIX) begin
            state_d = ST_COMMIT;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end else if (tmo_expired) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_COMMIT: begin
        // Reloading an active pulse stretches it rather than splitting it.
        intertime_d = shadow_q;
        ok_d        = 1'b1;
        pulse_d     = PW'(PULSE_CYCLES);
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    iss_d = (pulse_d != '0);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      shadow_q    <= '0;
      xor_q       <= '0;
      intertime_q <= '0;
      pulse_q     <= '0;
      iss_q       <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      xor_q       <= xor_d;
      intertime_q <= intertime_d;
      pulse_q     <= pulse_d;
      iss_q       <= iss_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_time_sync_rx.sv
// Scoreboard bench: dut_a uses a 1-cycle pulse, dut_b a 12-cycle pulse so a
// back-to-back commit lands inside the first pulse. Both use a 100-cycle timeout.
module tb_time_sync_rx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  time_sync_rx_if rxa();
  time_sync_rx_if rxb();

  logic [63:0] it_a, it_b;
  logic iss_a, busy_a, ok_a, err_a;
  logic iss_b, busy_b, ok_b, err_b;

  time_sync_rx #(.TIMEOUT_CYCLES(100), .PULSE_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .rx(rxa), .intertime(it_a), .issetintertime(iss_a),
    .busy(busy_a), .frame_ok(ok_a), .frame_err(err_a));

  time_sync_rx #(.TIMEOUT_CYCLES(100), .PULSE_CYCLES(12)) dut_b (
    .clk(clk), .rst(rst), .rx(rxb), .intertime(it_b), .issetintertime(iss_b),
    .busy(busy_b), .frame_ok(ok_b), .frame_err(err_b));

  typedef struct { bit ok; logic [63:0] val; int at; } exp_t;
  typedef struct { int len; logic [63:0] val; } run_t;

  exp_t qa[$];
  exp_t qb[$];
  run_t qrun[$];
  exp_t ea, eb;
  run_t er;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_it_a = '0;
  int last_t = 0;
  int run_b = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic strobe(input bit sel, input logic [7:0] b);
    @(negedge clk);
    if (sel) begin rxb.rx_data = b; rxb.rx_valid = 1'b1; end
    else     begin rxa.rx_data = b; rxa.rx_valid = 1'b1; end
    last_t = cyc;
  endtask

  task automatic idle(input bit sel, input int n);
    repeat (n) begin
      @(negedge clk);
      if (sel) rxb.rx_valid = 1'b0;
      else     rxa.rx_valid = 1'b0;
    end
  endtask

  // Sends a whole frame; ok is the hand-derived verdict for (p, c).
  task automatic send_frame(input bit sel, input logic [63:0] p, input logic [7:0] c,
                            input bit ok, input int gap);
    strobe(sel, 8'hA5); idle(sel, gap - 1);
    for (int i = 7; i >= 0; i--) begin
      strobe(sel, p[i*8 +: 8]); idle(sel, gap - 1);
    end
    strobe(sel, c);
    if (sel) begin
      qb.push_back('{1'b1, p, last_t + 2});
    end else if (ok) begin
      qa.push_back('{1'b1, p, last_t + 2});
      exp_it_a = p;
    end else begin
      qa.push_back('{1'b0, exp_it_a, last_t + 1});
    end
    idle(sel, 1);
  endtask

  // Monitor A: every frame_ok/frame_err pops one expected event.
  always @(negedge clk) begin
    if (!rst) begin
      if (ok_a || err_a) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event_a: got ok=%0b err=%0b expected none (cycle %0d)", ok_a, err_a, cyc);
        end else begin
          ea = qa.pop_front();
          chk("a_event_ok", 64'(ok_a), 64'(ea.ok));
          chk("a_event_cycle", 64'(cyc), 64'(ea.at));
          chk("a_intertime", it_a, ea.val);
          chk("a_ok_err_excl", 64'(ok_a & err_a), 64'd0);
          chk("a_iss_with_event", 64'(iss_a), 64'(ea.ok));
        end
      end else if (iss_a) begin
        chk("a_iss_without_commit", 64'(iss_a), 64'd0);
      end
    end
  end

  // Monitor B: commit values and length/value of each continuous pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (ok_b) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event_b: got ok at cycle %0d expected none", cyc);
        end else begin
          eb = qb.pop_front();
          chk("b_event_cycle", 64'(cyc), 64'(eb.at));
          chk("b_intertime", it_b, eb.val);
        end
      end
      if (err_b) chk("b_frame_err", 64'(err_b), 64'd0);
      if (iss_b) run_b++;
      else if (run_b != 0) begin
        if (qrun.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse_b: got run %0d expected none", run_b);
        end else begin
          er = qrun.pop_front();
          chk("b_pulse_run", 64'(run_b), 64'(er.len));
          chk("b_intertime_after_pulse", it_b, er.val);
        end
        run_b = 0;
      end
    end
  end

  initial begin
    rst = 1'b1;
    rxa.rx_valid = 1'b0; rxa.rx_data = '0;
    rxb.rx_valid = 1'b0; rxb.rx_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_intertime", it_a, 64'd0);
    chk("rst_iss", 64'(iss_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_ok_err", 64'({ok_a, err_a}), 64'd0);
    rst = 1'b0;
    idle(0, 2);

    // Noise in IDLE is ignored.
    strobe(0, 8'h12); idle(0, 9);
    strobe(0, 8'h34); idle(0, 1);
    chk("noise_busy", 64'(busy_a), 64'd0);
    idle(0, 8);

    // Valid frame; busy still high in COMMIT, low afterwards.
    send_frame(0, 64'h0000_0000_66D5_F0A0, 8'hE3, 1'b1, 10);
    chk("commit_busy", 64'(busy_a), 64'd1);
    idle(0, 1);
    chk("after_commit_busy", 64'(busy_a), 64'd0);
    idle(0, 10);

    // Bad checksum.
    send_frame(0, 64'h0000_0000_66D5_F0A0, 8'hE2, 1'b0, 10);
    idle(0, 10);

    // Stall after 3 payload bytes: error exactly 100 cycles after the last byte.
    strobe(0, 8'hA5); idle(0, 9);
    for (int i = 0; i < 3; i++) begin strobe(0, 8'h00); idle(0, 9); end
    qa.push_back('{1'b0, exp_it_a, last_t + 100});
    idle(0, 110);
    send_frame(0, 64'h0000_0000_1234_5678, 8'h08, 1'b1, 10);
    idle(0, 10);

    // Byte arriving in the very cycle the timeout would fire wins.
    send_frame(0, 64'h0000_0000_0000_0007, 8'h07, 1'b1, 99);
    idle(0, 10);

    // Embedded sync bytes, exact MAX_UNIX, and one above range.
    send_frame(0, 64'h0000_0000_A5A5_A501, 8'hA4, 1'b1, 10);
    idle(0, 10);
    send_frame(0, 64'h0000_0000_FFFF_FFFF, 8'h00, 1'b1, 10);
    idle(0, 10);
    send_frame(0, 64'h0000_0001_0000_0000, 8'h01, 1'b0, 10);
    idle(0, 10);

    // Back-to-back commits on dut_b: second lands inside the first pulse.
    send_frame(1, 64'h0000_0000_0000_0011, 8'h11, 1'b1, 1);
    qrun.push_back('{23, 64'h22});
    send_frame(1, 64'h0000_0000_0000_0022, 8'h22, 1'b1, 1);
    idle(1, 30);

    // Reset mid-frame clears everything; next frame is accepted.
    strobe(0, 8'hA5); idle(0, 9);
    for (int i = 0; i < 5; i++) begin strobe(0, 8'h00); idle(0, 9); end
    @(negedge clk); rst = 1'b1;
    #1;
    chk("midrst_intertime", it_a, 64'd0);
    chk("midrst_busy", 64'(busy_a), 64'd0);
    chk("midrst_iss_ok_err", 64'({iss_a, ok_a, err_a}), 64'd0);
    exp_it_a = '0;
    @(negedge clk); rst = 1'b0;
    idle(0, 5);
    send_frame(0, 64'h0000_0000_0000_002A, 8'h2A, 1'b1, 10);
    idle(0, 30);

    chk("pending_a", 64'(qa.size()), 64'd0);
    chk("pending_b", 64'(qb.size()), 64'd0);
    chk("pending_runs", 64'(qrun.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
